// File: rtl/dii_package.sv
// Debug interconnect flit type shared by the NoC control module slice.
// dii_flit: valid, last, data[15:0].
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/noc_control_module_rr_arb.sv
// Combinational round-robin pick: first set req bit after rr_last_i.
// Ports: req_i (requests), rr_last_i (last winner), grant_o (winner index).
module noc_control_module_rr_arb #(
    parameter int NUM_SRC = 2,
    parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   rr_last_i,
    output logic [SRC_W-1:0]   grant_o
);

    function automatic logic [SRC_W-1:0] wrap(input int v);
        return SRC_W'(v % NUM_SRC);
    endfunction

    // Walk from the farthest offset to the nearest so the source
    // closest after rr_last_i is assigned last and therefore wins.
    always_comb begin
        grant_o = rr_last_i;
        for (int i = NUM_SRC; i >= 1; i--) begin
            if (req_i[wrap(int'(rr_last_i) + i)]) begin
                grant_o = wrap(int'(rr_last_i) + i);
            end
        end
    end

endmodule

// File: rtl/noc_control_module_event_mux.sv
// Packet-atomic round-robin merge of submodule event streams.
// Ports: clk, rst (sync, active-high), in_flit/in_ready per source,
// out_flit/out_ready merged registered stream, len_err sticky flag.
module noc_control_module_event_mux
    import dii_package::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int MAX_DI_PKT_LEN = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  dii_flit [NUM_SRC-1:0] in_flit,
    output logic    [NUM_SRC-1:0] in_ready,
    output dii_flit               out_flit,
    input  logic                  out_ready,
    output logic                  len_err
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(MAX_DI_PKT_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_DI_PKT_LEN - 1);

    typedef enum logic {
        ARB,
        XFER
    } state_e;

    state_e           state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] rr_last_q, rr_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dii_flit          oreg_q, oreg_d;
    logic             err_q, err_d;

    logic [NUM_SRC-1:0] req;
    logic [SRC_W-1:0]   arb_grant;
    dii_flit            sel;
    logic               take;
    logic               fire;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req[i] = in_flit[i].valid;
        end
    end

    noc_control_module_rr_arb #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_arb (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .grant_o   (arb_grant)
    );

    // The output register can load whenever it is empty or draining.
    assign sel  = in_flit[grant_q];
    assign take = !oreg_q.valid || out_ready;
    assign fire = (state_q == XFER) && sel.valid && take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            grant_q   <= '0;
            rr_last_q <= SRC_W'(NUM_SRC - 1);
            cnt_q     <= '0;
            oreg_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            oreg_q    <= oreg_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        oreg_d    = oreg_q;
        err_d     = err_q;
        if (take) begin
            oreg_d.valid = 1'b0;
        end
        unique case (state_q)
            ARB: begin
                if (|req) begin
                    grant_d = arb_grant;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (fire) begin
                    oreg_d = sel;
                    cnt_d  = cnt_q + 1'b1;
                    // Flag only; the overlong packet is still forwarded.
                    if (!sel.last && cnt_q == CNT_LIM) begin
                        err_d = 1'b1;
                    end
                    if (sel.last) begin
                        rr_last_d = grant_q;
                        cnt_d     = '0;
                        state_d   = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        in_ready = '0;
        if (state_q == XFER) begin
            in_ready[grant_q] = take;
        end
    end

    assign out_flit = oreg_q;
    assign len_err  = err_q;

endmodule

// File: tb/tb_noc_control_module_event_mux.sv
// Directed bench for noc_control_module_event_mux.
// Cycle table for arbitration/latency, queue-driven sequences for corners.
module tb_noc_control_module_event_mux;
    import dii_package::*;

    logic          clk;
    logic          rst;
    dii_flit [1:0] in_flit;
    logic    [1:0] in_ready;
    dii_flit       out_flit;
    logic          out_ready;
    logic          len_err;

    int n_tests = 0;
    int n_fail  = 0;

    noc_control_module_event_mux #(
        .NUM_SRC        (2),
        .MAX_DI_PKT_LEN (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_ready (out_ready),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        v0;
        logic        l0;
        logic [15:0] d0;
        logic        v1;
        logic        l1;
        logic [15:0] d1;
        logic [1:0]  rdy;
        logic        ov;
        logic        ol;
        logic [15:0] od;
    } vec_t;

    vec_t tv[$];

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] rx[$];
    logic [16:0] ex[$];

    logic    fired0 = 1'b0;
    logic    fired1 = 1'b0;
    logic    prev_stall = 1'b0;
    dii_flit prev_out;
    logic    chk_no1 = 1'b0;
    int      n0 = 0;
    int      stall_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t V(
        input logic v0, input logic l0, input logic [15:0] d0,
        input logic v1, input logic l1, input logic [15:0] d1,
        input logic [1:0] rdy,
        input logic ov, input logic ol, input logic [15:0] od);
        vec_t t;
        t.v0 = v0; t.l0 = l0; t.d0 = d0;
        t.v1 = v1; t.l1 = l1; t.d1 = d1;
        t.rdy = rdy;
        t.ov = ov; t.ol = ol; t.od = od;
        return t;
    endfunction

    task automatic push_pkt(input int src, input logic [15:0] base,
                            input int n);
        logic [16:0] e;
        for (int i = 1; i <= n; i++) begin
            e = {(i == n), base + 16'(i)};
            if (src == 0) q0.push_back(e);
            else          q1.push_back(e);
            ex.push_back(e);
        end
    endtask

    task automatic tick(input logic ordy);
        @(posedge clk);
        #1;
        if (fired0) void'(q0.pop_front());
        if (fired1) void'(q1.pop_front());
        in_flit = '0;
        if (q0.size() > 0) begin
            in_flit[0].valid = 1'b1;
            in_flit[0].last  = q0[0][16];
            in_flit[0].data  = q0[0][15:0];
        end
        if (q1.size() > 0) begin
            in_flit[1].valid = 1'b1;
            in_flit[1].last  = q1[0][16];
            in_flit[1].data  = q1[0][15:0];
        end
        out_ready = ordy;
        @(negedge clk);
        if (prev_stall) chk("hold", out_flit, prev_out);
        if (out_flit.valid && !out_ready) begin
            stall_cnt++;
            chk("stall_in_ready", in_ready, 0);
        end
        if (chk_no1 && q0.size() > 0) chk("no_interleave", in_ready[1], 0);
        prev_stall = out_flit.valid && !out_ready;
        prev_out   = out_flit;
        fired0 = in_flit[0].valid && in_ready[0];
        fired1 = in_flit[1].valid && in_ready[1];
        if (fired0) n0++;
        if (out_flit.valid && out_ready) rx.push_back({out_flit.last, out_flit.data});
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int n = 0;
        do begin
            tick(1'b1);
            n++;
        end while ((q0.size() > 0 || q1.size() > 0 || out_flit.valid) && n < limit);
        chk({nm, "_done"}, (n < limit), 1);
    endtask

    task automatic check_rx(input string nm);
        chk({nm, "_count"}, rx.size(), ex.size());
        for (int i = 0; i < rx.size() && i < ex.size(); i++) begin
            chk($sformatf("%s_flit%0d", nm, i), rx[i], ex[i]);
        end
        rx.delete();
        ex.delete();
    endtask

    initial begin
        // Contention: A then B, then C (src0) wins again over D.
        tv.push_back(V(1,0,16'hA001, 1,0,16'hB001, 2'b00, 0,0,16'h0000));
        tv.push_back(V(1,0,16'hA001, 1,0,16'hB001, 2'b01, 0,0,16'h0000));
        tv.push_back(V(1,0,16'hA002, 1,0,16'hB001, 2'b01, 1,0,16'hA001));
        tv.push_back(V(1,1,16'hA003, 1,0,16'hB001, 2'b01, 1,0,16'hA002));
        tv.push_back(V(0,0,16'h0000, 1,0,16'hB001, 2'b00, 1,1,16'hA003));
        tv.push_back(V(0,0,16'h0000, 1,0,16'hB001, 2'b10, 0,0,16'h0000));
        tv.push_back(V(0,0,16'h0000, 1,0,16'hB002, 2'b10, 1,0,16'hB001));
        tv.push_back(V(0,0,16'h0000, 1,1,16'hB003, 2'b10, 1,0,16'hB002));
        tv.push_back(V(1,0,16'hC001, 1,0,16'hD001, 2'b00, 1,1,16'hB003));
        tv.push_back(V(1,0,16'hC001, 1,0,16'hD001, 2'b01, 0,0,16'h0000));
        tv.push_back(V(1,0,16'hC002, 1,0,16'hD001, 2'b01, 1,0,16'hC001));
        tv.push_back(V(1,1,16'hC003, 1,0,16'hD001, 2'b01, 1,0,16'hC002));
        tv.push_back(V(0,0,16'h0000, 1,0,16'hD001, 2'b00, 1,1,16'hC003));
        tv.push_back(V(0,0,16'h0000, 1,0,16'hD001, 2'b10, 0,0,16'h0000));
        tv.push_back(V(0,0,16'h0000, 1,0,16'hD002, 2'b10, 1,0,16'hD001));
        tv.push_back(V(0,0,16'h0000, 1,1,16'hD003, 2'b10, 1,0,16'hD002));
        tv.push_back(V(0,0,16'h0000, 0,0,16'h0000, 2'b00, 1,1,16'hD003));
        tv.push_back(V(0,0,16'h0000, 0,0,16'h0000, 2'b00, 0,0,16'h0000));
        // Single 5-flit packet from source 0.
        tv.push_back(V(1,0,16'h0001, 0,0,16'h0000, 2'b00, 0,0,16'h0000));
        tv.push_back(V(1,0,16'h0001, 0,0,16'h0000, 2'b01, 0,0,16'h0000));
        tv.push_back(V(1,0,16'h0002, 0,0,16'h0000, 2'b01, 1,0,16'h0001));
        tv.push_back(V(1,0,16'h0003, 0,0,16'h0000, 2'b01, 1,0,16'h0002));
        tv.push_back(V(1,0,16'h0004, 0,0,16'h0000, 2'b01, 1,0,16'h0003));
        tv.push_back(V(1,1,16'h0005, 0,0,16'h0000, 2'b01, 1,0,16'h0004));
        tv.push_back(V(0,0,16'h0000, 0,0,16'h0000, 2'b00, 1,1,16'h0005));
        tv.push_back(V(0,0,16'h0000, 0,0,16'h0000, 2'b00, 0,0,16'h0000));

        rst       = 1'b1;
        in_flit   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_flit", out_flit, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_len_err", len_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int r = 0; r < tv.size(); r++) begin
            @(posedge clk);
            #1;
            in_flit[0] = {tv[r].v0, tv[r].l0, tv[r].d0};
            in_flit[1] = {tv[r].v1, tv[r].l1, tv[r].d1};
            out_ready  = 1'b1;
            @(negedge clk);
            chk($sformatf("tv%0d_in_ready", r), in_ready, tv[r].rdy);
            chk($sformatf("tv%0d_valid", r), out_flit.valid, tv[r].ov);
            if (tv[r].ov) begin
                chk($sformatf("tv%0d_last", r), out_flit.last, tv[r].ol);
                chk($sformatf("tv%0d_data", r), out_flit.data, tv[r].od);
            end
            chk($sformatf("tv%0d_len_err", r), len_err, 0);
        end

        // Backpressure: ready 1,0,0,1 while a 4-flit packet streams.
        stall_cnt = 0;
        push_pkt(0, 16'h3000, 4);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        wait_idle("bp", 40);
        chk("bp_stalls", stall_cnt, 2);
        check_rx("bp");

        // Source 1 requests mid-packet of source 0.
        push_pkt(0, 16'h4000, 4);
        tick(1'b1);
        tick(1'b1);
        chk_no1 = 1'b1;
        push_pkt(1, 16'h5000, 3);
        wait_idle("ilv", 40);
        chk_no1 = 1'b0;
        check_rx("ilv");

        // Overlong packet: 13 flits, flag after the 12th is accepted.
        begin
            int k = 0;
            n0 = 0;
            push_pkt(0, 16'h6000, 13);
            while (n0 < 12 && k < 100) begin
                tick(1'b1);
                k++;
            end
            chk("len_12th_seen", n0, 12);
            chk("len_before", len_err, 0);
            tick(1'b1);
            chk("len_rise", len_err, 1);
            wait_idle("len", 60);
            check_rx("len");
            repeat (3) tick(1'b1);
            chk("len_sticky", len_err, 1);
        end

        // Reset after 2 of 6 flits, then both sources request.
        begin
            int k = 0;
            n0 = 0;
            push_pkt(0, 16'h7000, 6);
            while (n0 < 2 && k < 100) begin
                tick(1'b1);
                k++;
            end
            chk("rstm_2_seen", n0, 2);
            @(posedge clk);
            #1;
            rst = 1'b1;
            q0.delete();
            fired0 = 1'b0;
            fired1 = 1'b0;
            prev_stall = 1'b0;
            in_flit = '0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rstm_valid", out_flit.valid, 0);
            chk("rstm_in_ready", in_ready, 0);
            chk("rstm_len_err", len_err, 0);
            rx.delete();
            ex.delete();
            push_pkt(0, 16'h8000, 2);
            push_pkt(1, 16'h9000, 2);
            wait_idle("rstm", 40);
            check_rx("rstm");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
